// File: rtl/seq_tx_pkg.sv
// Shared constants and state encoding for the 1111001 pattern transmitter.
package seq_tx_pkg;

  localparam int              PLEN    = 7;
  localparam logic [PLEN-1:0] PATTERN = 7'b1111001;
  localparam int              OVL     = 1;

  localparam int IDX_W = 3;
  localparam int REP_W = 4;
  localparam int GAP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_1111001_tx.sv
// Serial pattern generator driving a 1111001 detector, with repeat count,
// idle gaps, overlapped chaining and the expected detector output.
module seq_1111001_tx
  import seq_tx_pkg::state_e, seq_tx_pkg::IDLE, seq_tx_pkg::SEND, seq_tx_pkg::GAP;
#(
  parameter int              PLEN    = seq_tx_pkg::PLEN,
  parameter logic [PLEN-1:0] PATTERN = seq_tx_pkg::PATTERN,
  parameter int              OVL     = seq_tx_pkg::OVL
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [seq_tx_pkg::REP_W-1:0] count,
  input  logic [seq_tx_pkg::GAP_W-1:0] gap,
  input  logic                         overlap,
  output logic                         x,
  output logic                         valid,
  output logic                         busy,
  output logic                         done,
  output logic                         exp_z
);

  localparam int IDX_W = seq_tx_pkg::IDX_W;
  localparam int REP_W = seq_tx_pkg::REP_W;
  localparam int GAP_W = seq_tx_pkg::GAP_W;

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PLEN - 1);
  localparam logic [IDX_W-1:0] IDX_OVL = IDX_W'(PLEN - 1 - OVL);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic [GAP_W-1:0]   gap_lat_q, gap_lat_d;
  logic               ovl_q, ovl_d;
  logic               x_q, x_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               exp_z_q, exp_z_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rep_q     <= '0;
      gcnt_q    <= '0;
      gap_lat_q <= '0;
      ovl_q     <= 1'b0;
      x_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      exp_z_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gcnt_q    <= gcnt_d;
      gap_lat_q <= gap_lat_d;
      ovl_q     <= ovl_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      exp_z_q   <= exp_z_d;
    end
  end

  // Next state first, then outputs decoded from the next state so every
  // output is a flop that lines up with the state it describes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gcnt_d    = gcnt_q;
    gap_lat_d = gap_lat_q;
    ovl_d     = ovl_q;
    x_d       = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    exp_z_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = SEND;
            idx_d     = IDX_TOP;
            rep_d     = count;
            gap_lat_d = gap;
            ovl_d     = overlap;
          end
        end
      end

      SEND: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          rep_d   = '0;
          gcnt_d  = '0;
        end else if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          // Pattern end: rep_q counts patterns still owed including this one.
          if (rep_q != '0) rep_d = rep_q - 1'b1;
          if (rep_q <= REP_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (gap_lat_q != '0) begin
            state_d = GAP;
            gcnt_d  = gap_lat_q;
          end else if (ovl_q) begin
            idx_d = IDX_OVL;
          end else begin
            idx_d = IDX_TOP;
          end
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          rep_d   = '0;
          gcnt_d  = '0;
        end else if (gcnt_q <= GAP_W'(1)) begin
          state_d = SEND;
          idx_d   = IDX_TOP;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    case (state_d)
      SEND: begin
        x_d     = PATTERN[idx_d];
        valid_d = 1'b1;
        busy_d  = 1'b1;
        exp_z_d = (idx_d == '0);
      end
      GAP: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign exp_z = exp_z_q;

endmodule

// File: tb/tb_seq_1111001_tx.sv
// Directed bench for seq_1111001_tx: vector table plus multi-cycle sequences.
module tb_seq_1111001_tx;

  logic       clk = 1'b0;
  logic       rst, start, abort, overlap;
  logic [3:0] count;
  logic [2:0] gap;
  logic       x, valid, busy, done, exp_z;

  int total = 0;
  int bad   = 0;

  seq_1111001_tx dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .count(count), .gap(gap), .overlap(overlap),
    .x(x), .valid(valid), .busy(busy), .done(done), .exp_z(exp_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, start, abort, ovl;
    logic [3:0] cnt;
    logic [2:0] gp;
    logic       ex, ev, eb, ed, ez;
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic ex, input logic ev,
                         input logic eb, input logic ed, input logic ez);
    chk({name, ".x"}, x, ex);
    chk({name, ".valid"}, valid, ev);
    chk({name, ".busy"}, busy, eb);
    chk({name, ".done"}, done, ed);
    chk({name, ".exp_z"}, exp_z, ez);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a transmission and checks n bits against hand-written strings,
  // then the done cycle. junk drives start and config garbage while busy.
  task automatic run_seq(input string name, input logic [3:0] cnt, input logic [2:0] gp,
                         input logic ov, input int n, input logic [31:0] xs,
                         input logic [31:0] zs, input logic junk, input logic det);
    logic [6:0] hist;
    logic       z_ref;
    hist = '0;
    start = 1'b1; abort = 1'b0; count = cnt; gap = gp; overlap = ov;
    tick();
    if (junk) begin
      start = 1'b1; count = 4'hf; gap = 3'd7; overlap = ~ov;
    end else begin
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      chk_all($sformatf("%s.bit%0d", name, i + 1), xs[n-1-i], 1'b1, 1'b1, 1'b0, zs[n-1-i]);
      if (det) begin
        hist  = {hist[5:0], x};
        z_ref = valid && (hist == 7'b1111001);
        chk($sformatf("%s.det%0d", name, i + 1), z_ref, exp_z);
      end
      if (i == n - 1) start = 1'b0;
      tick();
    end
    chk_all({name, ".end"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  vec_t tbl[12];

  initial begin
    // basic single pattern, then count=0 done pulse
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b0; start = 1'b0; abort = 1'b0; count = '0; gap = '0; overlap = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
      count = tbl[i].cnt; gap = tbl[i].gp; overlap = tbl[i].ovl;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ev, tbl[i].eb, tbl[i].ed, tbl[i].ez);
    end

    // overlapped chaining with detector cross-check
    run_seq("ovl3", 4'd3, 3'd0, 1'b1, 19, 32'b1111001_111001_111001,
            32'b0000001_000001_000001, 1'b0, 1'b1);
    // started in the done cycle; config changes and start while busy ignored
    run_seq("noovl2", 4'd2, 3'd0, 1'b0, 14, 32'b1111001_1111001,
            32'b0000001_0000001, 1'b1, 1'b0);
    // gap overrides overlap
    run_seq("gap3", 4'd2, 3'd3, 1'b1, 17, 32'b1111001_000_1111001,
            32'b0000001_000_0000001, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    chk_all("idle_after_gap3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // abort at bit 10 of a count=4 run
    start = 1'b1; count = 4'd4; gap = 3'd0; overlap = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk_all("abort.bit10", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_all("abort.next", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("abort.nodone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq("after_abort", 4'd1, 3'd0, 1'b0, 7, 32'b1111001, 32'b0000001, 1'b0, 1'b0);

    // abort wins over start in IDLE
    start = 1'b1; abort = 1'b1; count = 4'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_all("abort_vs_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("abort_vs_start2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset during the 4th bit, start during busy ignored
    start = 1'b1; count = 4'd2; gap = 3'd1;
    tick();
    for (int i = 1; i < 4; i++) tick();
    chk_all("rst.bit4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("rst.clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; start = 1'b0;
    tick();
    chk_all("rst.stay", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; count = 4'd0;
    tick();
    start = 1'b0;
    chk_all("rst.cnt0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("rst.cnt0_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_1111001_tx.md
SEQ_1111001_TX -- requirements
Module: seq_1111001_tx

Interface
REQ-001 Parameter PATTERN, default 7'b1111001, is the pattern bits, sent MSB first.
REQ-002 Parameter PLEN, default 7, is the pattern length in bits.
REQ-003 Parameter OVL, default 1, is the prefix/suffix overlap length of PATTERN in bits.
REQ-004 Port clk, input, 1, is the single clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1, is a synchronous, active-low reset.
REQ-006 Port start, input, 1, is a transmit request, sampled only in IDLE.
REQ-007 Port abort, input, 1, terminates a transmission in progress.
REQ-008 Port count, input, 4, is the number of pattern repetitions, latched at start.
REQ-009 Port gap, input, 3, is the number of idle zero bits between patterns, latched at start.
REQ-010 Port overlap, input, 1, selects overlapped chaining when 1, latched at start.
REQ-011 Port x, output, 1, is the serial data bit that feeds the mealy_overlapping_1111001 x input.
REQ-012 Port valid, output, 1, is high while x carries a pattern bit or a gap bit.
REQ-013 Port busy, output, 1, is high in the SEND and GAP states.
REQ-014 Port done, output, 1, is a one-cycle pulse when all repetitions are complete.
REQ-015 Port exp_z, output, 1, is the expected detector z; it is high in the cycle x carries the last bit of each pattern.

Function
REQ-016 The FSM SHALL have three states: IDLE, SEND and GAP; all outputs SHALL be registered.
REQ-017 When in IDLE with start=1 and abort=0, count, gap and overlap SHALL be latched, and in the next cycle the FSM SHALL be in SEND with x=PATTERN[PLEN-1] and valid=1 (latency of 1 cycle).
REQ-018 If start=1 with count=0, the block SHALL stay in IDLE, keep valid=0 and busy=0, and pulse done in the next cycle.
REQ-019 In SEND, x SHALL carry one pattern bit per cycle, MSB first, with a bit index running PLEN-1 down to 0.
REQ-020 exp_z SHALL be 1 exactly in the cycle that bit index 0 is driven, and 0 in every other cycle.
REQ-021 After a pattern's last bit with repetitions remaining and latched gap>0, the FSM SHALL enter GAP and drive x=0 and valid=1 for exactly gap cycles, then send a full pattern.
REQ-022 After a pattern's last bit with repetitions remaining, gap=0 and overlap=0, the next cycle SHALL send the full pattern starting at index PLEN-1.
REQ-023 After a pattern's last bit with repetitions remaining, gap=0 and overlap=1, the next pattern SHALL start at index PLEN-1-OVL, omitting the shared prefix bits.
REQ-024 In the overlap case of REQ-023, the total bit count SHALL be PLEN+(count-1)*(PLEN-OVL).
REQ-025 gap>0 SHALL override overlap, and no bits SHALL be skipped after a gap.
REQ-026 The repetition counter SHALL decrement at each pattern end and SHALL never underflow or wrap.
REQ-027 The cycle after the last bit of the final pattern, the FSM SHALL be in IDLE with done=1, busy=0, valid=0 and x=0.
REQ-028 abort=1 in SEND or GAP SHALL, in the next cycle, force IDLE with x=0, valid=0, busy=0, exp_z=0 and no done pulse.
REQ-029 start=1 while busy SHALL be ignored, and changes to count, gap or overlap during busy SHALL have no effect.
REQ-030 If abort=1 and start=1 in the same IDLE cycle, abort SHALL win and no transmission SHALL start.
REQ-031 In IDLE, x SHALL be 0.
REQ-032 start SHALL be accepted in the same cycle done is high.

Reset
REQ-033 When rst=0 at a clock edge, the FSM SHALL go to IDLE, and x, valid, busy, done and exp_z SHALL all be 0; the counters and latched inputs SHALL be cleared.
REQ-034 Reset SHALL take precedence over start and abort, including when asserted in mid-transmission, with no done pulse.

Structure
REQ-035 Package seq_tx_pkg SHALL hold PATTERN, PLEN, OVL and the state enum {IDLE, SEND, GAP}.
REQ-036 The block SHALL be a single module with no sub-module, containing the FSM, a 3-bit bit-index counter, a 4-bit repetition counter and a 3-bit gap counter.

Verification
REQ-037 count=1, gap=0, overlap=0, start pulse: x SHALL be 1,1,1,1,0,0,1 over 7 cycles, with exp_z only on the 7th and done on the 8th.
REQ-038 count=3, gap=0, overlap=1: x SHALL be 1111001 111001 111001 (19 bits), with exp_z on bits 7, 13 and 19 and a connected mealy_overlapping_1111001 z matching exp_z.
REQ-039 count=2, gap=3, overlap=1: x SHALL be 1111001 000 1111001 (17 bits), with valid high for all 17, exp_z on bits 7 and 17, and done on the 18th cycle.
REQ-040 count=4 with abort at bit 10: x=0, busy=0 and valid=0 next cycle, no done pulse, and a following start SHALL transmit normally.
REQ-041 rst=0 during the 4th bit: all outputs SHALL be 0 at the next edge, a start during busy SHALL be ignored, and count=0 SHALL give a done pulse with valid never high.
